// File: rtl/gpio_pad_pkg.sv
// Shared constants and types for the GPIO pad input conditioning blocks.
`timescale 1ns/1ps
package gpio_pad_pkg;

   localparam int unsigned SYNC_STAGES = 2;
   localparam int unsigned CNT_W_DEF   = 4;
   localparam int unsigned WIDTH_DEF   = 8;

   typedef logic [CNT_W_DEF-1:0] filt_cnt_t;

   localparam logic FILT_RST_VAL = 1'b0;

endpackage

// File: rtl/gpio_pad_filter_bit.sv
// One pad bit: synchroniser, stability counter, filtered level and edge pulses.
// With GPIO_FILT_EDGE_IRQ_EN defined it also exposes the pulse-set terms for the IRQ unit.
`timescale 1ns/1ps
module gpio_pad_filter_bit
   import gpio_pad_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pad_in,
   input  logic [CNT_W-1:0] filt_len,
   output logic             filt_out,
   output logic             rise_pulse,
   output logic             fall_pulse
`ifdef GPIO_FILT_EDGE_IRQ_EN
   ,
   output logic             rise_set_c,
   output logic             fall_set_c
`endif
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s2;
   logic [CNT_W-1:0]       cnt;
   logic [CNT_W-1:0]       cnt_nxt;
   logic                   filt_nxt;
   logic                   filt_d;
   logic                   rise_nxt;
   logic                   fall_nxt;

   assign s2 = sync_q[SYNC_STAGES-1];

   // Accept s2 only once it has disagreed with filt_out for filt_len+1 samples.
   always_comb begin
      cnt_nxt  = '0;
      filt_nxt = filt_out;
      if (s2 != filt_out) begin
         if (cnt >= filt_len) begin
            filt_nxt = s2;
         end else begin
            cnt_nxt = cnt + CNT_W'(1);
         end
      end
   end

   assign rise_nxt = filt_out & ~filt_d;
   assign fall_nxt = ~filt_out & filt_d;

`ifdef GPIO_FILT_EDGE_IRQ_EN
   assign rise_set_c = rise_nxt;
   assign fall_set_c = fall_nxt;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q     <= {SYNC_STAGES{FILT_RST_VAL}};
         cnt        <= '0;
         filt_out   <= FILT_RST_VAL;
         filt_d     <= FILT_RST_VAL;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], pad_in};
         cnt        <= cnt_nxt;
         filt_out   <= filt_nxt;
         filt_d     <= filt_out;
         rise_pulse <= rise_nxt;
         fall_pulse <= fall_nxt;
      end
   end

endmodule

// File: rtl/gpio_pad_input_filter.sv
// Bank of glitch-filtered GPIO pad inputs with edge pulses.
// Define GPIO_FILT_EDGE_IRQ_EN to add the sticky edge-interrupt unit and irq_* ports.
`timescale 1ns/1ps
module gpio_pad_input_filter
   import gpio_pad_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] pad_in,
   input  logic [CNT_W-1:0] filt_len,
   output logic [WIDTH-1:0] filt_out,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse
`ifdef GPIO_FILT_EDGE_IRQ_EN
   ,
   input  logic [WIDTH-1:0] irq_rise_en,
   input  logic [WIDTH-1:0] irq_fall_en,
   input  logic [WIDTH-1:0] irq_clr,
   output logic [WIDTH-1:0] irq_status,
   output logic             irq
`endif
);

`ifdef GPIO_FILT_EDGE_IRQ_EN
   logic [WIDTH-1:0] rise_set_c;
   logic [WIDTH-1:0] fall_set_c;
   logic [WIDTH-1:0] irq_set_c;
`endif

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      gpio_pad_filter_bit #(
         .CNT_W (CNT_W)
      ) u_bit (
         .clk        (clk),
         .rst_n      (rst_n),
         .pad_in     (pad_in[i]),
         .filt_len   (filt_len),
         .filt_out   (filt_out[i]),
         .rise_pulse (rise_pulse[i]),
         .fall_pulse (fall_pulse[i])
`ifdef GPIO_FILT_EDGE_IRQ_EN
         ,
         .rise_set_c (rise_set_c[i]),
         .fall_set_c (fall_set_c[i])
`endif
      );
   end

`ifdef GPIO_FILT_EDGE_IRQ_EN
   // Flags set on the same edge the pulse asserts; set beats a simultaneous clear.
   assign irq_set_c = (rise_set_c & irq_rise_en) | (fall_set_c & irq_fall_en);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_status <= '0;
         irq        <= 1'b0;
      end else begin
         irq_status <= (irq_status & ~irq_clr) | irq_set_c;
         irq        <= |irq_status;
      end
   end
`endif

endmodule

// File: tb/tb_gpio_pad_input_filter.sv
// Directed self-checking bench for gpio_pad_input_filter (IRQ checks when GPIO_FILT_EDGE_IRQ_EN is defined).
`timescale 1ns/1ps
module tb_gpio_pad_input_filter;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned CNT_W = 4;

   logic             clk;
   logic             rst_n;
   logic [WIDTH-1:0] pad_in;
   logic [CNT_W-1:0] filt_len;
   logic [WIDTH-1:0] filt_out;
   logic [WIDTH-1:0] rise_pulse;
   logic [WIDTH-1:0] fall_pulse;
`ifdef GPIO_FILT_EDGE_IRQ_EN
   logic [WIDTH-1:0] irq_rise_en;
   logic [WIDTH-1:0] irq_fall_en;
   logic [WIDTH-1:0] irq_clr;
   logic [WIDTH-1:0] irq_status;
   logic             irq;
`endif

   int checks;
   int errors;

   gpio_pad_input_filter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pad_in     (pad_in),
      .filt_len   (filt_len),
      .filt_out   (filt_out),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse)
`ifdef GPIO_FILT_EDGE_IRQ_EN
      ,
      .irq_rise_en (irq_rise_en),
      .irq_fall_en (irq_fall_en),
      .irq_clr     (irq_clr),
      .irq_status  (irq_status),
      .irq         (irq)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance past one rising edge; inputs driven after this are seen at the next edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n    = 1'b1;
      pad_in   = '0;
      filt_len = '0;
`ifdef GPIO_FILT_EDGE_IRQ_EN
      irq_rise_en = '0;
      irq_fall_en = '0;
      irq_clr     = '0;
`endif
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if (filt_out !== 8'h00) begin errors++; $display("FAIL reset_filt_out got %h exp 00", filt_out); end
      checks++;
      if (rise_pulse !== 8'h00) begin errors++; $display("FAIL reset_rise got %h exp 00", rise_pulse); end
      checks++;
      if (fall_pulse !== 8'h00) begin errors++; $display("FAIL reset_fall got %h exp 00", fall_pulse); end
`ifdef GPIO_FILT_EDGE_IRQ_EN
      checks++;
      if (irq_status !== 8'h00 || irq !== 1'b0) begin
         errors++; $display("FAIL reset_irq got %h/%b exp 00/0", irq_status, irq);
      end
`endif
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_no_filter();
      filt_len = 4'd0;
      pad_in   = 8'h01;
      tick(); tick();
      checks++;
      if (filt_out !== 8'h00) begin errors++; $display("FAIL nf_early got %h exp 00", filt_out); end
      tick();
      checks++;
      if (filt_out !== 8'h01) begin errors++; $display("FAIL nf_filt_rise got %h exp 01", filt_out); end
      checks++;
      if (rise_pulse !== 8'h00) begin errors++; $display("FAIL nf_rise_early got %h exp 00", rise_pulse); end
      tick();
      checks++;
      if (rise_pulse !== 8'h01) begin errors++; $display("FAIL nf_rise got %h exp 01", rise_pulse); end
      tick();
      checks++;
      if (rise_pulse !== 8'h00) begin errors++; $display("FAIL nf_rise_width got %h exp 00", rise_pulse); end
      pad_in = 8'h00;
      tick(); tick(); tick();
      checks++;
      if (filt_out !== 8'h00 || fall_pulse !== 8'h00) begin
         errors++; $display("FAIL nf_filt_fall got %h/%h exp 00/00", filt_out, fall_pulse);
      end
      tick();
      checks++;
      if (fall_pulse !== 8'h01) begin errors++; $display("FAIL nf_fall got %h exp 01", fall_pulse); end
      tick();
      checks++;
      if (fall_pulse !== 8'h00) begin errors++; $display("FAIL nf_fall_width got %h exp 00", fall_pulse); end
   endtask

   task automatic test_glitch();
      filt_len = 4'd3;
      pad_in   = 8'h04;
      for (int i = 0; i < 3; i++) tick();
      pad_in = 8'h00;
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if (filt_out !== 8'h00 || rise_pulse !== 8'h00) begin
            errors++; $display("FAIL glitch_%0d got %h/%h exp 00/00", i, filt_out, rise_pulse);
         end
      end
      pad_in = 8'h04;
      for (int i = 0; i < 5; i++) tick();
      checks++;
      if (filt_out !== 8'h00) begin errors++; $display("FAIL pulse5_early got %h exp 00", filt_out); end
      pad_in = 8'h00;
      tick();
      checks++;
      if (filt_out !== 8'h04) begin errors++; $display("FAIL pulse5_accept got %h exp 04", filt_out); end
      tick();
      checks++;
      if (rise_pulse !== 8'h04) begin errors++; $display("FAIL pulse5_rise got %h exp 04", rise_pulse); end
      for (int i = 0; i < 10; i++) tick();
      checks++;
      if (filt_out !== 8'h00) begin errors++; $display("FAIL pulse5_settle got %h exp 00", filt_out); end
   endtask

   task automatic test_len_change();
      filt_len = 4'd15;
      pad_in   = 8'h02;
      for (int i = 0; i < 10; i++) tick();
      checks++;
      if (filt_out !== 8'h00) begin errors++; $display("FAIL len_mid got %h exp 00", filt_out); end
      filt_len = 4'd4;
      tick();
      checks++;
      if (filt_out !== 8'h02) begin errors++; $display("FAIL len_shrink got %h exp 02", filt_out); end
      pad_in = 8'h00;
      for (int i = 0; i < 12; i++) tick();
      checks++;
      if (filt_out !== 8'h00) begin errors++; $display("FAIL len_settle got %h exp 00", filt_out); end
   endtask

   task automatic test_reset_held();
      filt_len = 4'd2;
      pad_in   = 8'hFF;
      rst_n    = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if (filt_out !== 8'h00) begin errors++; $display("FAIL held_early got %h exp 00", filt_out); end
      tick();
      checks++;
      if (filt_out !== 8'hFF) begin errors++; $display("FAIL held_filt got %h exp ff", filt_out); end
      checks++;
      if (rise_pulse !== 8'h00) begin errors++; $display("FAIL held_rise_early got %h exp 00", rise_pulse); end
      tick();
      checks++;
      if (rise_pulse !== 8'hFF) begin errors++; $display("FAIL held_rise got %h exp ff", rise_pulse); end
      tick();
      checks++;
      if (rise_pulse !== 8'h00) begin errors++; $display("FAIL held_rise_single got %h exp 00", rise_pulse); end
   endtask

   task automatic test_reset_mid_count();
      filt_len = 4'd15;
      pad_in   = 8'h00;
      for (int i = 0; i < 5; i++) tick();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (filt_out !== 8'h00 || rise_pulse !== 8'h00 || fall_pulse !== 8'h00) begin
         errors++; $display("FAIL midrst_async got %h/%h/%h exp 00/00/00", filt_out, rise_pulse, fall_pulse);
      end
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if (filt_out !== 8'h00 || rise_pulse !== 8'h00 || fall_pulse !== 8'h00) begin
            errors++; $display("FAIL midrst_release_%0d got %h/%h/%h exp 00/00/00", i, filt_out, rise_pulse, fall_pulse);
         end
      end
   endtask

`ifdef GPIO_FILT_EDGE_IRQ_EN
   task automatic test_irq();
      filt_len    = 4'd0;
      irq_rise_en = 8'h01;
      irq_fall_en = 8'h00;
      pad_in      = 8'h01;
      tick(); tick(); tick();
      irq_clr = 8'h01;
      tick();
      irq_clr = 8'h00;
      checks++;
      if (rise_pulse !== 8'h01 || irq_status !== 8'h01) begin
         errors++; $display("FAIL irq_set_wins got %h/%h exp 01/01", rise_pulse, irq_status);
      end
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL irq_lag got %b exp 0", irq); end
      tick();
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL irq_assert got %b exp 1", irq); end
      irq_clr = 8'h01;
      tick();
      irq_clr = 8'h00;
      checks++;
      if (irq_status !== 8'h00) begin errors++; $display("FAIL irq_clear got %h exp 00", irq_status); end
      tick();
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL irq_deassert got %b exp 0", irq); end
      pad_in = 8'h00;
      for (int i = 0; i < 6; i++) tick();
      checks++;
      if (irq_status !== 8'h00 || irq !== 1'b0) begin
         errors++; $display("FAIL irq_fall_masked got %h/%b exp 00/0", irq_status, irq);
      end
   endtask
`endif

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_no_filter();
      test_glitch();
      test_len_change();
      test_reset_held();
      test_reset_mid_count();
`ifdef GPIO_FILT_EDGE_IRQ_EN
      test_irq();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
